// File: rtl/asteroid_motion_unit.sv
// Asteroid motion unit: derives the pixel-rate clock and strobe from the
// system clock, alternates the run-animation sprite frame, and walks the
// asteroid offset diagonally across the play field with wrap-around.
module asteroid_motion_unit #(
  parameter int SPRITE_DIV = 2500000,
  parameter int MOVE_DIV   = 250000,
  parameter int X_STEP     = 1,
  parameter int Y_STEP     = 1,
  parameter int X_LIMIT    = 540,
  parameter int Y_LIMIT    = 380
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       halt,
  input  logic       restart,
  input  logic       asteroid_on,
  output logic       pix_clk,
  output logic       pix_tick,
  output logic       sprite,
  output logic [9:0] xmovaddr,
  output logic [9:0] ymovaddr
);

  localparam int SPRITE_W = (SPRITE_DIV > 1) ? $clog2(SPRITE_DIV) : 1;
  localparam int MOVE_W   = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [SPRITE_W-1:0] SPRITE_LAST = SPRITE_W'(SPRITE_DIV - 1);
  localparam logic [MOVE_W-1:0]   MOVE_LAST   = MOVE_W'(MOVE_DIV - 1);
  localparam logic [10:0]         X_STEP_W    = 11'(X_STEP);
  localparam logic [10:0]         Y_STEP_W    = 11'(Y_STEP);
  localparam logic [10:0]         X_LIMIT_W   = 11'(X_LIMIT);
  localparam logic [10:0]         Y_LIMIT_W   = 11'(Y_LIMIT);

  logic [1:0]          div_cnt;
  logic [SPRITE_W-1:0] sprite_cnt;
  logic [MOVE_W-1:0]   move_cnt;
  logic                move_en;
  logic [10:0]         x_sum;
  logic [10:0]         y_sum;
  logic [9:0]          x_next;
  logic [9:0]          y_next;

  // Free-running divide-by-four counter that sets the pixel rate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= 2'd0;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  // Pixel clock is the counter MSB; the strobe decodes the last phase
  assign pix_clk  = div_cnt[1];
  assign pix_tick = (div_cnt == 2'd3);

  // Motion only advances on a pixel strobe while the game is live
  assign move_en = pix_tick & ~halt & asteroid_on;

  // Wrap arithmetic kept one bit wider so an overflowing sum still wraps
  assign x_sum  = {1'b0, xmovaddr} + X_STEP_W;
  assign y_sum  = {1'b0, ymovaddr} + Y_STEP_W;
  assign x_next = (x_sum >= X_LIMIT_W) ? 10'd0 : x_sum[9:0];
  assign y_next = (y_sum >= Y_LIMIT_W) ? 10'd0 : y_sum[9:0];

  // Sprite frame flips every SPRITE_DIV pixel strobes, regardless of game state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sprite_cnt <= '0;
      sprite     <= 1'b1;
    end else if (pix_tick) begin
      if (sprite_cnt == SPRITE_LAST) begin
        sprite_cnt <= '0;
        sprite     <= ~sprite;
      end else begin
        sprite_cnt <= sprite_cnt + SPRITE_W'(1);
      end
    end
  end

  // Asteroid stepping: restart wins over freeze, freeze holds the count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      move_cnt <= '0;
      xmovaddr <= 10'd0;
      ymovaddr <= 10'd0;
    end else if (restart) begin
      move_cnt <= '0;
      xmovaddr <= 10'd0;
      ymovaddr <= 10'd0;
    end else if (move_en) begin
      if (move_cnt == MOVE_LAST) begin
        move_cnt <= '0;
        xmovaddr <= x_next;
        ymovaddr <= y_next;
      end else begin
        move_cnt <= move_cnt + MOVE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_asteroid_motion_unit.sv
// Directed self-checking bench for asteroid_motion_unit using a small
// parameter set so sprite toggles, steps and wraps happen within a few
// hundred clocks. Cycle index k counts rising edges since reset release.
module tb_asteroid_motion_unit;

  logic       clk;
  logic       reset;
  logic       halt;
  logic       restart;
  logic       asteroid_on;
  logic       pix_clk;
  logic       pix_tick;
  logic       sprite;
  logic [9:0] xmovaddr;
  logic [9:0] ymovaddr;

  int total;
  int bad;
  int k;

  asteroid_motion_unit #(
    .SPRITE_DIV(4),
    .MOVE_DIV  (2),
    .X_STEP    (3),
    .Y_STEP    (2),
    .X_LIMIT   (8),
    .Y_LIMIT   (6)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .halt       (halt),
    .restart    (restart),
    .asteroid_on(asteroid_on),
    .pix_clk    (pix_clk),
    .pix_tick   (pix_tick),
    .sprite     (sprite),
    .xmovaddr   (xmovaddr),
    .ymovaddr   (ymovaddr)
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at k=%0d: got %0d expected %0d", tag, k, observed, expected);
    end
  endtask

  // Drive the control inputs together
  task automatic applyStimulus(input logic h, input logic r, input logic a);
    halt        = h;
    restart     = r;
    asteroid_on = a;
  endtask

  // Advance one rising edge and return on the following falling edge
  task automatic stepCycle();
    @(posedge clk);
    k++;
    @(negedge clk);
  endtask

  task automatic runTo(input int target);
    while (k < target) stepCycle();
  endtask

  task automatic checkPos(input string tag, input int ex, input int ey);
    checkOutput({tag, "_x"}, 32'(xmovaddr), 32'(ex));
    checkOutput({tag, "_y"}, 32'(ymovaddr), 32'(ey));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Held in reset across a couple of edges
    repeat (2) @(negedge clk);
    checkOutput("rst_pix_clk", 32'(pix_clk), 32'd0);
    checkOutput("rst_pix_tick", 32'(pix_tick), 32'd0);
    checkOutput("rst_sprite", 32'(sprite), 32'd1);
    checkPos("rst", 0, 0);

    // Release on a falling edge; pixel clock 0,0,1,1 and strobe on phase 3
    reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      stepCycle();
      checkOutput("pix_clk", 32'(pix_clk), ((k % 4) >= 2) ? 32'd1 : 32'd0);
      checkOutput("pix_tick", 32'(pix_tick), ((k % 4) == 3) ? 32'd1 : 32'd0);
    end

    // Sprite flips after 16 clocks; no motion while asteroid_on is low
    runTo(15);
    checkOutput("sprite_k15", 32'(sprite), 32'd1);
    checkPos("off_k15", 0, 0);
    runTo(16);
    checkOutput("sprite_k16", 32'(sprite), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);

    // Enabled: strobes at edges 20,24,... ; step every second strobe
    runTo(23);
    checkPos("one_tick", 0, 0);
    runTo(24);
    checkPos("step1", 3, 2);
    runTo(31);
    checkOutput("sprite_k31", 32'(sprite), 32'd0);
    runTo(32);
    checkPos("step2", 6, 4);
    checkOutput("sprite_k32", 32'(sprite), 32'd1);
    runTo(40);
    checkPos("wrap", 0, 0);

    // Reach (3,2) then one more strobe so the move count is 1, then freeze
    runTo(48);
    checkPos("step4", 3, 2);
    runTo(52);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runTo(79);
    checkOutput("sprite_halt_k79", 32'(sprite), 32'd1);
    runTo(80);
    checkOutput("sprite_halt_k80", 32'(sprite), 32'd0);
    runTo(92);
    checkPos("halt_hold", 3, 2);

    // Unfreeze: first strobe completes the held count
    applyStimulus(1'b0, 1'b0, 1'b1);
    runTo(95);
    checkPos("pre_resume", 3, 2);
    runTo(96);
    checkPos("resume", 6, 4);

    // One more strobe leaves move count at 1, then freeze and restart
    runTo(100);
    checkPos("cnt1", 6, 4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    runTo(101);
    applyStimulus(1'b1, 1'b1, 1'b1);
    runTo(102);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkPos("restart", 0, 0);
    checkOutput("restart_pix_clk", 32'(pix_clk), 32'd1);
    checkOutput("restart_pix_tick", 32'(pix_tick), 32'd0);
    checkOutput("restart_sprite", 32'(sprite), 32'd1);

    // Cleared move count needs two strobes before the next step
    applyStimulus(1'b0, 1'b0, 1'b1);
    runTo(104);
    checkPos("post_restart_1", 0, 0);
    runTo(108);
    checkPos("post_restart_2", 3, 2);

    // Asynchronous reset between edges, while every output is non-reset
    runTo(123);
    checkPos("pre_areset", 6, 4);
    checkOutput("pre_areset_tick", 32'(pix_tick), 32'd1);
    checkOutput("pre_areset_sprite", 32'(sprite), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("areset_pix_clk", 32'(pix_clk), 32'd0);
    checkOutput("areset_pix_tick", 32'(pix_tick), 32'd0);
    checkOutput("areset_sprite", 32'(sprite), 32'd1);
    checkPos("areset", 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
